updown_load_counter: RTL
========================

Name: updown_load_counter

Overview:
- DUT-side responder for the router interface. It consumes load/updown/data_in driven by the BFM and produces data_out sampled by the monitor.
- Implements a loadable up/down counter with an arm-on-first-load state machine, wrap flags and a wrap-event counter.
- Sits directly under the testbench top. Its ports connect one-to-one to the interface signals of the same name.

Parameters:
- WIDTH, 8, width of data_in/data_out and the count register.
- STEP, 1, increment/decrement magnitude per cycle; legal range 1..2**WIDTH-1.
- WRAP_CNT_W, 4, width of the wrap-event counter.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- resetn  input  1  synchronous reset, active-high; asserted = 1, sampled on posedge clk.
- load  input  1  when 1, count register takes data_in this cycle.
- updown  input  1  1 = count up, 0 = count down; ignored while load=1.
- data_in  input  WIDTH  load value.
- data_out  output  WIDTH  registered count value.
- armed  output  1  1 once the first load has been accepted since reset.
- wrap_up  output  1  one-cycle pulse: up-count crossed 2**WIDTH-1 -> low values.
- wrap_dn  output  1  one-cycle pulse: down-count crossed 0 -> high values.
- wrap_cnt  output  WRAP_CNT_W  number of wrap events since the last load; saturates at all-ones.

Behaviour:
- Reset (resetn=1 at posedge):
  - data_out=0, armed=0, wrap_up=0, wrap_dn=0, wrap_cnt=0, state=IDLE.
  - Reset overrides load and any count in progress, with no partial update.
- FSM has two states, IDLE and RUN.
  - IDLE: data_out held, no counting; updown ignored. load=1 -> data_out<=data_in, state<=RUN, armed<=1.
  - RUN: load=1 -> data_out<=data_in, wrap_cnt<=0, no wrap pulse. load=0 -> count by STEP in the direction given by updown.
  - RUN returns to IDLE only via reset.
- Latency: one cycle. A value or count triggered at posedge N is visible on data_out after posedge N. The monitor samples it #1 before posedge N+1.
- Arithmetic: WIDTH+1-bit internal sum; data_out takes the low WIDTH bits (modulo 2**WIDTH).
  - Up: wrap_up=1 for one cycle when data_out+STEP >= 2**WIDTH.
  - Down: wrap_dn=1 for one cycle when data_out < STEP.
- wrap_cnt increments on each wrap_up or wrap_dn pulse and holds at 2**WRAP_CNT_W-1. A load clears it, and load takes priority in the same cycle.
- wrap_up and wrap_dn are never both 1. Both are 0 in any cycle with load=1, reset, or state IDLE.
- Direction may change every cycle with no dead cycle.
- Load of the current value still counts as a load: wrap_cnt is cleared and no count occurs.
- X on updown while load=1 must not propagate to data_out.

Optional Feature:
- Macro SATURATE_EN.
- Defined:
  - Up-count clamps data_out at 2**WIDTH-1; down-count clamps at 0.
  - wrap_up/wrap_dn pulse in the cycle the clamp engages, i.e. when the requested move exceeds the limit, including repeated attempts at the limit.
  - wrap_cnt counts clamp events under the same rules.
- Undefined: modulo wrap as described in Behaviour.
- Ports are identical in both builds.

Test Plan:
- Reset then 5 idle cycles with load=0, updown toggling -> data_out=0, armed=0, no wrap pulses.
- load=1, data_in=8'h10, then updown=1 for 3 cycles (STEP=1) -> data_out 10,11,12,13; armed=1 from the first cycle.
- load 8'hFE, updown=1 for 3 cycles -> data_out FF,00,01; wrap_up pulses once (at FF->00); wrap_cnt=1. With SATURATE_EN -> FF,FF,FF; wrap_up pulses twice; wrap_cnt=2.
- load 8'h01, updown=0 for 2 cycles -> 00, FF; wrap_dn once; then load 8'h55 with updown=0 -> data_out=55, wrap_cnt=0, no pulse.
- Assert resetn mid-count from data_out=8'h40 with load=1, data_in=8'hAA in the same cycle -> data_out=0, armed=0; the next counting cycle without a load leaves data_out at 0.
- Alternate updown every cycle for 20 cycles from 8'h80 -> data_out alternates 81/80; no wrap; wrap_cnt=0.

Source files
------------

// File: rtl/updown_load_counter_if.sv
// -----------------------------------------------------------------------------
// updown_load_counter_if
//
// Purpose:
//   Bundles the load/count request signals and the counter status outputs that
//   pass between the stimulus driver and the updown_load_counter responder.
//
// Signals:
//   load      driver -> counter   1           take data_in as the new count
//   updown    driver -> counter   1           1 = count up, 0 = count down
//   data_in   driver -> counter   WIDTH       load value
//   data_out  counter -> driver   WIDTH       registered count value
//   armed     counter -> driver   1           first load accepted since reset
//   wrap_up   counter -> driver   1           one-cycle up-wrap / up-clamp pulse
//   wrap_dn   counter -> driver   1           one-cycle down-wrap / down-clamp pulse
//   wrap_cnt  counter -> driver   WRAP_CNT_W  wrap events since last load
//
// Modports:
//   master  the side that issues load/updown/data_in (testbench BFM)
//   slave   the counter itself
// -----------------------------------------------------------------------------
interface updown_load_counter_if #(
  parameter int WIDTH      = 8,
  parameter int WRAP_CNT_W = 4
);

  logic                  load;
  logic                  updown;
  logic [WIDTH-1:0]      data_in;
  logic [WIDTH-1:0]      data_out;
  logic                  armed;
  logic                  wrap_up;
  logic                  wrap_dn;
  logic [WRAP_CNT_W-1:0] wrap_cnt;

  modport master (
    output load,
    output updown,
    output data_in,
    input  data_out,
    input  armed,
    input  wrap_up,
    input  wrap_dn,
    input  wrap_cnt
  );

  modport slave (
    input  load,
    input  updown,
    input  data_in,
    output data_out,
    output armed,
    output wrap_up,
    output wrap_dn,
    output wrap_cnt
  );

endinterface

// File: rtl/updown_load_counter.sv
// -----------------------------------------------------------------------------
// updown_load_counter
//
// Purpose:
//   Loadable up/down counter with an arm-on-first-load state machine
//   (IDLE -> RUN), one-cycle wrap pulses and a saturating wrap-event counter.
//   All outputs are registered; a load or count issued at posedge N is visible
//   right after posedge N.
//
// Ports:
//   clk     input   1   single clock, all state changes on posedge
//   resetn  input   1   synchronous reset, active-high (1 = reset)
//   bus     slave modport of updown_load_counter_if:
//             load, updown, data_in          (inputs)
//             data_out, armed, wrap_up,
//             wrap_dn, wrap_cnt              (outputs)
//
// Parameters:
//   WIDTH       count / data width
//   STEP        magnitude of each count step, 1 .. 2**WIDTH-1
//   WRAP_CNT_W  width of the wrap-event counter
//
// Build option:
//   SATURATE_EN  when defined, counting clamps at 2**WIDTH-1 / 0 instead of
//                wrapping modulo 2**WIDTH. The wrap pulses then mark each
//                cycle the clamp engages (including repeated attempts while
//                already at the limit) and wrap_cnt counts those events.
//                Ports are identical in both builds.
// -----------------------------------------------------------------------------
module updown_load_counter #(
  parameter int          WIDTH      = 8,
  parameter int unsigned STEP       = 1,
  parameter int          WRAP_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  updown_load_counter_if.slave bus
);

  // STEP widened by one bit so the carry/borrow lands in bit WIDTH.
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------

  // True when v+STEP does not fit in WIDTH bits.
  function automatic logic up_overflow(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] s;
    s = {1'b0, v} + STEP_X;
    return s[WIDTH];
  endfunction

  // True when v-STEP would go below zero (v < STEP).
  function automatic logic dn_underflow(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] d;
    d = {1'b0, v} - STEP_X;
    return d[WIDTH];
  endfunction

  // Next count for an up step: modulo wrap, or clamp at all-ones.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] r;
    s = {1'b0, v} + STEP_X;
`ifdef SATURATE_EN
    r = s[WIDTH] ? '1 : s[WIDTH-1:0];
`else
    r = s[WIDTH-1:0];
`endif
    return r;
  endfunction

  // Next count for a down step: modulo wrap, or clamp at zero.
  function automatic logic [WIDTH-1:0] step_dn(input logic [WIDTH-1:0] v);
    logic [WIDTH:0]   d;
    logic [WIDTH-1:0] r;
    d = {1'b0, v} - STEP_X;
`ifdef SATURATE_EN
    r = d[WIDTH] ? '0 : d[WIDTH-1:0];
`else
    r = d[WIDTH-1:0];
`endif
    return r;
  endfunction

  // Wrap-event counter increment that holds at all-ones.
  function automatic logic [WRAP_CNT_W-1:0] sat_inc(input logic [WRAP_CNT_W-1:0] c);
    logic [WRAP_CNT_W-1:0] r;
    r = (&c) ? c : c + WRAP_CNT_W'(1);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                state_q;
  logic [WIDTH-1:0]      count_q;
  logic                  armed_q;
  logic                  wrap_up_q;
  logic                  wrap_dn_q;
  logic [WRAP_CNT_W-1:0] wrap_cnt_q;

  // Next-count and wrap decisions for a counting cycle in RUN; only used
  // when load=0, so updown (possibly X alongside a load) never reaches
  // count_q during a load.
  logic [WIDTH-1:0]      count_step_d;
  logic                  wrap_up_d;
  logic                  wrap_dn_d;

  always_comb begin
    count_step_d = count_q;
    wrap_up_d    = 1'b0;
    wrap_dn_d    = 1'b0;
    if (bus.updown) begin
      count_step_d = step_up(count_q);
      wrap_up_d    = up_overflow(count_q);
    end else begin
      count_step_d = step_dn(count_q);
      wrap_dn_d    = dn_underflow(count_q);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q    <= IDLE;
      count_q    <= '0;
      armed_q    <= 1'b0;
      wrap_up_q  <= 1'b0;
      wrap_dn_q  <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      // Pulses default low; only a counting cycle in RUN can raise them.
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            count_q    <= bus.data_in;
            wrap_cnt_q <= '0;
            armed_q    <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (bus.load) begin
            // A load always wins, even when data_in equals the current count.
            count_q    <= bus.data_in;
            wrap_cnt_q <= '0;
          end else begin
            count_q   <= count_step_d;
            wrap_up_q <= wrap_up_d;
            wrap_dn_q <= wrap_dn_d;
            if (wrap_up_d || wrap_dn_d) begin
              wrap_cnt_q <= sat_inc(wrap_cnt_q);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_out = count_q;
  assign bus.armed    = armed_q;
  assign bus.wrap_up  = wrap_up_q;
  assign bus.wrap_dn  = wrap_dn_q;
  assign bus.wrap_cnt = wrap_cnt_q;

endmodule
